bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 13 +
 rtl/bus_arb_fsm.sv | 69 ++++++
 rtl/bus_arbiter.sv | 71 +++++++
 tb/tb_bus_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-device bus arbiter: FSM state encoding and device indices.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN1 = 2'd1,
      OWN2 = 2'd2
   } state_t;

   localparam logic DEV1 = 1'b0;
   localparam logic DEV2 = 1'b1;

endpackage

// File: rtl/bus_arb_fsm.sv
// Ownership FSM with round-robin pointer and burst counter; grants are decoded from the state register.
module bus_arb_fsm
   import bus_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_1,
   input  logic req_2,
   input  logic last_1,
   input  logic last_2,
   output logic gnt_1,
   output logic gnt_2
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   state_t     state;
   logic       ptr;
   logic [3:0] cnt;
   logic [3:0] cnt_inc;

   assign cnt_inc = cnt + 4'd1;
   assign gnt_1   = (state == OWN1);
   assign gnt_2   = (state == OWN2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= DEV1;
         cnt   <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= 4'd0;
               if (req_1 && (!req_2 || ptr == DEV1))
                  state <= OWN1;
               else if (req_2)
                  state <= OWN2;
            end
            OWN1: begin
               // Keep the bus only while the owner is still transferring and the burst is not over.
               if (req_1 && !last_1 && cnt_inc != MAX_CNT) begin
                  cnt <= cnt_inc;
               end else begin
                  cnt   <= 4'd0;
                  ptr   <= DEV2;
                  state <= req_2 ? OWN2 : IDLE;
               end
            end
            OWN2: begin
               if (req_2 && !last_2 && cnt_inc != MAX_CNT) begin
                  cnt <= cnt_inc;
               end else begin
                  cnt   <= 4'd0;
                  ptr   <= DEV1;
                  state <= req_1 ? OWN1 : IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-device shared-bus arbiter: grant FSM plus registered bus/receive datapath.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int N         = 8,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_1,
   input  logic         req_2,
   input  logic         last_1,
   input  logic         last_2,
   input  logic [N-1:0] data_in_1,
   input  logic [N-1:0] data_in_2,
   output logic         gnt_1,
   output logic         gnt_2,
   output logic         select,
   output logic [N-1:0] bus,
   output logic [N-1:0] data_out_1,
   output logic [N-1:0] data_out_2,
   output logic         rx_valid_1,
   output logic         rx_valid_2
);

   logic xfer_1;
   logic xfer_2;

   bus_arb_fsm #(
      .MAX_BURST (MAX_BURST)
   ) u_fsm (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_1  (req_1),
      .req_2  (req_2),
      .last_1 (last_1),
      .last_2 (last_2),
      .gnt_1  (gnt_1),
      .gnt_2  (gnt_2)
   );

   // A non-owner's request never moves data.
   assign xfer_1 = gnt_1 && req_1;
   assign xfer_2 = gnt_2 && req_2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         select     <= DEV1;
         bus        <= '0;
         data_out_1 <= '0;
         data_out_2 <= '0;
         rx_valid_1 <= 1'b0;
         rx_valid_2 <= 1'b0;
      end else begin
         rx_valid_1 <= 1'b0;
         rx_valid_2 <= 1'b0;
         if (xfer_1) begin
            bus        <= data_in_1;
            data_out_2 <= data_in_1;
            rx_valid_2 <= 1'b1;
            select     <= DEV1;
         end else if (xfer_2) begin
            bus        <= data_in_2;
            data_out_1 <= data_in_2;
            rx_valid_1 <= 1'b1;
            select     <= DEV2;
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against an owner/queue-level reference model.
module tb_bus_arbiter;

   localparam int N  = 8;
   localparam int MB = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_1 = 1'b0, req_2 = 1'b0, last_1 = 1'b0, last_2 = 1'b0;
   logic [N-1:0] data_in_1 = '0, data_in_2 = '0;
   logic         gnt_1, gnt_2, select, rx_valid_1, rx_valid_2;
   logic [N-1:0] bus, data_out_1, data_out_2;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: who owns the bus, how many words it has moved, who wins the next tie.
   int           owner;
   int           words;
   int           next_pri;
   logic [N-1:0] m_bus, m_do1, m_do2;
   logic         m_rv1, m_rv2, m_sel;

   bus_arbiter #(.N(N), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_1(req_1), .req_2(req_2), .last_1(last_1), .last_2(last_2),
      .data_in_1(data_in_1), .data_in_2(data_in_2),
      .gnt_1(gnt_1), .gnt_2(gnt_2), .select(select), .bus(bus),
      .data_out_1(data_out_1), .data_out_2(data_out_2),
      .rx_valid_1(rx_valid_1), .rx_valid_2(rx_valid_2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      owner = 0; words = 0; next_pri = 1;
      m_bus = '0; m_do1 = '0; m_do2 = '0; m_rv1 = 0; m_rv2 = 0; m_sel = 0;
   endfunction

   function automatic void model_step(input bit r1, input bit r2, input bit l1, input bit l2,
                                      input logic [N-1:0] d1, input logic [N-1:0] d2);
      bit wants, done, other_req;
      m_rv1 = 0; m_rv2 = 0;
      if (owner == 0) begin
         if (r1 && r2)  owner = next_pri;
         else if (r1)   owner = 1;
         else if (r2)   owner = 2;
         words = 0;
      end else begin
         wants = (owner == 1) ? r1 : r2;
         done  = 1;
         if (wants) begin
            if (owner == 1) begin m_bus = d1; m_do2 = d1; m_rv2 = 1; m_sel = 0; end
            else            begin m_bus = d2; m_do1 = d2; m_rv1 = 1; m_sel = 1; end
            words++;
            done = ((owner == 1) ? l1 : l2) || (words == MB);
         end
         if (done) begin
            next_pri  = 3 - owner;
            other_req = (owner == 1) ? r2 : r1;
            owner     = other_req ? 3 - owner : 0;
            words     = 0;
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step(req_1, req_2, last_1, last_2, data_in_1, data_in_2);
      #1;
      chk("gnt_1", 32'(gnt_1), 32'(owner == 1));
      chk("gnt_2", 32'(gnt_2), 32'(owner == 2));
      chk("select", 32'(select), 32'(m_sel));
      chk("bus", 32'(bus), 32'(m_bus));
      chk("data_out_1", 32'(data_out_1), 32'(m_do1));
      chk("data_out_2", 32'(data_out_2), 32'(m_do2));
      chk("rx_valid_1", 32'(rx_valid_1), 32'(m_rv1));
      chk("rx_valid_2", 32'(rx_valid_2), 32'(m_rv2));
   end

   task automatic drive(input bit r1, input bit r2, input bit l1, input bit l2,
                        input logic [N-1:0] d1, input logic [N-1:0] d2);
      @(negedge clk);
      req_1 = r1; req_2 = r2; last_1 = l1; last_2 = l2; data_in_1 = d1; data_in_2 = d2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      req_1 = 0; req_2 = 0; last_1 = 0; last_2 = 0;
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_gnt", 32'({gnt_1, gnt_2}), 32'd0);
      chk("rst_bus", 32'(bus), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single one-word burst from device 1
      drive(1, 0, 1, 0, 8'hA5, 8'h00);
      @(negedge clk);
      chk("d1_gnt", 32'(gnt_1), 32'd1);
      @(negedge clk);
      chk("d1_bus", 32'(bus), 32'hA5);
      chk("d1_do2", 32'(data_out_2), 32'hA5);
      chk("d1_rv2", 32'(rx_valid_2), 32'd1);
      chk("d1_idle", 32'({gnt_1, gnt_2}), 32'd0);
      req_1 = 0; last_1 = 0;
      @(negedge clk);
      chk("d1_rv2_off", 32'(rx_valid_2), 32'd0);

      // Contention after reset: device 1 first, then zero-gap handover to device 2
      do_reset();
      drive(1, 1, 1, 1, 8'h11, 8'h22);
      @(negedge clk);
      chk("ct_gnt1", 32'({gnt_1, gnt_2}), 32'b10);
      @(negedge clk);
      chk("ct_gnt2", 32'({gnt_1, gnt_2}), 32'b01);
      chk("ct_bus1", 32'(bus), 32'h11);
      req_1 = 0;
      @(negedge clk);
      chk("ct_sel", 32'(select), 32'd1);
      chk("ct_bus2", 32'(bus), 32'h22);
      req_2 = 0; last_1 = 0; last_2 = 0;
      @(negedge clk);

      // Device 2 streams without last: forced release after MB words
      drive(0, 1, 0, 0, 8'h00, 8'd1);
      @(negedge clk);
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         data_in_2 = 8'(k);
      end
      chk("mb_do1", 32'(data_out_1), 32'd4);
      chk("mb_release", 32'(gnt_2), 32'd0);
      req_2 = 0;
      @(negedge clk);

      // Device 1 abandons after two words: no third strobe, device 2 wins the next tie
      drive(1, 0, 0, 0, 8'h31, 8'h00);
      @(negedge clk);
      @(negedge clk); data_in_1 = 8'h32;
      @(negedge clk); req_1 = 0;
      @(negedge clk);
      chk("ab_rv2", 32'(rx_valid_2), 32'd0);
      chk("ab_do2", 32'(data_out_2), 32'h32);
      chk("ab_gnt", 32'(gnt_1), 32'd0);
      drive(1, 1, 0, 0, 8'h41, 8'h42);
      @(negedge clk);
      chk("ab_ptr", 32'({gnt_1, gnt_2}), 32'b01);
      req_1 = 0; req_2 = 0;
      @(negedge clk);
      @(negedge clk);

      // Reset in the middle of a device 2 burst
      drive(0, 1, 0, 0, 8'h00, 8'h77);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_gnt", 32'({gnt_1, gnt_2}), 32'd0);
      chk("mr_out", 32'({bus, data_out_1, rx_valid_1}), 32'd0);
      @(negedge clk);
      req_2 = 1; req_1 = 1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_regrant", 32'({gnt_1, gnt_2}), 32'b10);
      req_1 = 0; req_2 = 0;
      @(negedge clk);

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            drive($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 65,
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
                  N'($urandom), N'($urandom));
         end
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
